// File: rtl/addsub_arbiter.sv
// addsub_arbiter: two-requester arbiter that time-shares one external adder_sub unit
// and returns a held response per requester; round-robin on ties.
module addsub_arbiter #(
    parameter int LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic [1:0]  req0_op,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [1:0]  req1_op,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        req1_ready,
    output logic        rsp0_valid,
    output logic [31:0] rsp0_result,
    output logic        rsp0_cout,
    output logic        rsp0_gt,
    output logic        rsp0_eq,
    output logic        rsp0_err,
    input  logic        rsp0_ready,
    output logic        rsp1_valid,
    output logic [31:0] rsp1_result,
    output logic        rsp1_cout,
    output logic        rsp1_gt,
    output logic        rsp1_eq,
    output logic        rsp1_err,
    input  logic        rsp1_ready,
    output logic [31:0] au_a,
    output logic [31:0] au_b,
    output logic        au_isAdd,
    output logic        au_isSub,
    output logic        au_isCmp,
    input  logic [31:0] au_result,
    input  logic        au_cout,
    input  logic        au_gt,
    input  logic        au_eq,
    output logic [15:0] ops_done
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        owner_q, owner_d, last_q, last_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic        cout_q, cout_d, gt_q, gt_d, eq_q, eq_d, err_q, err_d;
    logic [15:0] ops_q, ops_d;
    logic        idle, exec, resp, gnt, accept, run, show0, show1;
    logic [1:0]  sel_op;

    always_comb begin
        idle       = reset && state_q == IDLE;
        exec       = state_q == EXEC;
        resp       = state_q == RESP;
        // tie goes to whoever was not served last
        gnt        = (req0_valid && req1_valid) ? ~last_q : req1_valid;
        req0_ready = idle && req0_valid && !gnt;
        req1_ready = idle && req1_valid && gnt;
        accept     = req0_ready || req1_ready;
        sel_op     = gnt ? req1_op : req0_op;
        state_d    = state_q;
        cnt_d      = cnt_q;
        owner_d    = owner_q;
        last_d     = last_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        res_d      = res_q;
        cout_d     = cout_q;
        gt_d       = gt_q;
        eq_d       = eq_q;
        err_d      = err_q;
        ops_d      = ops_q;
        if (accept) begin
            owner_d = gnt;
            op_d    = sel_op;
            a_d     = gnt ? req1_a : req0_a;
            b_d     = gnt ? req1_b : req0_b;
            cnt_d   = '0;
            state_d = sel_op == 2'd3 ? RESP : EXEC;
            err_d   = sel_op == 2'd3;
            res_d   = '0;
            cout_d  = 1'b0;
            gt_d    = 1'b0;
            eq_d    = 1'b0;
        end
        if (exec) begin
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'(LAT)) begin
                res_d   = au_result;
                cout_d  = au_cout;
                gt_d    = au_gt;
                eq_d    = au_eq;
                err_d   = 1'b0;
                cnt_d   = '0;
                state_d = RESP;
            end
        end
        if (resp && (owner_q ? rsp1_ready : rsp0_ready)) begin
            last_d  = owner_q;
            ops_d   = ops_q + 16'd1;
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cout_q  <= 1'b0;
            gt_q    <= 1'b0;
            eq_q    <= 1'b0;
            err_q   <= 1'b0;
            ops_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cout_q  <= cout_d;
            gt_q    <= gt_d;
            eq_q    <= eq_d;
            err_q   <= err_d;
            ops_q   <= ops_d;
        end
    end

    always_comb begin
        show0       = reset && resp && !owner_q;
        show1       = reset && resp && owner_q;
        run         = reset && exec;
        rsp0_valid  = show0;
        rsp0_result = show0 ? res_q : '0;
        rsp0_cout   = show0 && cout_q;
        rsp0_gt     = show0 && gt_q;
        rsp0_eq     = show0 && eq_q;
        rsp0_err    = show0 && err_q;
        rsp1_valid  = show1;
        rsp1_result = show1 ? res_q : '0;
        rsp1_cout   = show1 && cout_q;
        rsp1_gt     = show1 && gt_q;
        rsp1_eq     = show1 && eq_q;
        rsp1_err    = show1 && err_q;
        au_a        = run ? a_q : '0;
        au_b        = run ? b_q : '0;
        au_isAdd    = run && op_q == 2'd0;
        au_isSub    = run && op_q == 2'd1;
        au_isCmp    = run && op_q == 2'd2;
        ops_done    = ops_q;
    end
endmodule

// File: doc/addsub_arbiter.md
ADDSUB_ARBITER -- requirements
Module: addsub_arbiter

Interface
REQ-001 Parameter: LAT, default 1, shared adder_sub result latency in clock cycles (legal 1..4).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-004 reqN_valid (N=0,1)  input  1  requester N presents an operation.
REQ-005 reqN_op  input  2  00 ADD, 01 SUB, 10 CMP, 11 illegal.
REQ-006 reqN_a, reqN_b  input  32  operands.
REQ-007 reqN_ready  output  1  request N accepted this cycle when reqN_valid is also 1.
REQ-008 rspN_valid  output  1  response for requester N available.
REQ-009 rspN_result  output  32  captured Result; 0 on error.
REQ-010 rspN_cout, rspN_gt, rspN_eq, rspN_err  output  1 each  captured flags; err is 1 only for illegal op.
REQ-011 rspN_ready  input  1  requester N consumes the response.
REQ-012 au_a, au_b  output  32  operands to the shared adder_sub.
REQ-013 au_isAdd, au_isSub, au_isCmp  output  1 each  one-hot op strobes to the shared unit.
REQ-014 au_result  input  32; au_cout, au_gt, au_eq  input  1 each  shared unit outputs.
REQ-015 ops_done  output  16  count of completed responses.

Function
REQ-016 FSM states: IDLE, EXEC, RESP; exactly one state active.
REQ-017 IDLE: grant = sole valid requester; if both are valid, the one not granted last; reqN_ready = 1 only for the granted N; all other ready outputs 0.
REQ-018 Outside IDLE, req0_ready = req1_ready = 0.
REQ-019 Handshake in IDLE: on accept, latch op, a, b and grant owner; legal op -> EXEC, illegal op -> RESP with err = 1 and result/cout/gt/eq = 0.
REQ-020 EXEC: lasts exactly LAT+1 cycles, counted by an internal counter that is cleared on entry.
REQ-021 EXEC drives latched operands and exactly one strobe matching the op in every EXEC cycle.
REQ-022 Outside EXEC, au_a = au_b = 0 and all strobes = 0.
REQ-023 On the closing edge of the last EXEC cycle, capture au_result, au_cout, au_gt, au_eq into the owner's response registers; err = 0; -> RESP.
REQ-024 Latency: accept at cycle t -> rspN_valid = 1 from cycle t+LAT+2 for a legal op, and from cycle t+1 for an illegal op.
REQ-025 RESP: rspN_valid = 1 for the owner only; response fields are held stable while rspN_ready = 0, for any number of cycles.
REQ-026 RESP with rspN_ready = 1: update last-grant to the owner, increment ops_done (wraps 0xFFFF -> 0x0000), -> IDLE; the response is not re-presented.
REQ-027 A request arriving from the other requester during EXEC/RESP waits unaccepted; no request is dropped, and no new request is accepted in the cycle RESP completes.
REQ-028 Minimum spacing between accepts is LAT+3 cycles for legal ops and 2 cycles for illegal ops.
REQ-029 Changes on reqN inputs after acceptance do not affect the in-flight operation.

Reset
REQ-030 reset = 0 at a rising edge: state <- IDLE, counter <- 0, last-grant <- 1 (so requester 0 wins the first tie), ops_done <- 0.
REQ-031 During and after reset: all rsp valid, result and flag outputs <- 0; au outputs <- 0; ready outputs 0 while reset = 0.
REQ-032 Reset mid-EXEC or mid-RESP abandons the operation and emits no response for it.

Verification
REQ-033 LAT=1: req0 ADD a=15 b=10, rsp0_ready=1 -> au_isAdd high 2 cycles; rsp0_valid at t+3; result=25, err=0; ops_done=1.
REQ-034 req1 SUB 20,5 then CMP 30,10 then CMP 25,25 -> results 15; gt=1 eq=0; eq=1 gt=0; flags equal au_* as sampled at capture.
REQ-035 Both valid from reset, repeated 4 times -> grants in order 0,1,0,1; no two strobes are ever simultaneously high.
REQ-036 req0 op=11 -> rsp0_valid at t+1, err=1, result=0; au strobes never assert.
REQ-037 rsp1_ready held 0 for 5 cycles with req0 valid -> rsp1 fields stable, req0_ready=0 throughout; req0 is accepted the cycle after rsp1 completes plus one IDLE cycle.
REQ-038 reset=0 during EXEC of CMP 10,20, then release -> no rsp valid, ops_done=0, next request completes normally (result from the new operands).
